// File: rtl/ahb_uart_tx_arb_if.sv
// Requester/write-FIFO bundle for the UART TX arbiter.
// Ports: req_i/last_i/data_i (requester side), ack_o, grant_o, busy_o,
//        wf_full_i (FIFO back-pressure), wf_we_o/wf_wdata_o (FIFO write port).
// The master modport is the requester/FIFO environment; the slave modport is the arbiter.
interface ahb_uart_tx_arb_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 8
);
  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        last_i;
  logic [NREQ*DWIDTH-1:0] data_i;
  logic [NREQ-1:0]        ack_o;
  logic [NREQ-1:0]        grant_o;
  logic                   wf_full_i;
  logic                   wf_we_o;
  logic [DWIDTH-1:0]      wf_wdata_o;
  logic                   busy_o;

  modport master (
    output req_i, last_i, data_i, wf_full_i,
    input  ack_o, grant_o, wf_we_o, wf_wdata_o, busy_o
  );

  modport slave (
    input  req_i, last_i, data_i, wf_full_i,
    output ack_o, grant_o, wf_we_o, wf_wdata_o, busy_o
  );
endinterface

// File: rtl/ahb_uart_tx_arb.sv
// Round-robin arbiter sharing the UART TX write FIFO between NREQ byte streams.
// A grant is held for a whole packet (or MAX_BURST bytes), then a one-cycle
// IDLE bubble re-arbitrates starting just after the previous owner.
// Ports: hclk, hresetn (sync, active-low), bus (slave modport of ahb_uart_tx_arb_if).
//   ack_o / wf_we_o / wf_wdata_o are combinational; grant_o / busy_o are registered.
module ahb_uart_tx_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  ahb_uart_tx_arb_if.slave  bus
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q,  gidx_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [DWIDTH-1:0]  data_arr [NREQ];
  logic               found_c;
  logic [PTR_W-1:0]   win_c;
  logic               accept_c;
  logic               release_c;
  logic [NREQ-1:0]    ack_c;

  // Unpack the flat requester data bus.
  for (genvar r = 0; r < NREQ; r++) begin : g_unpack
    assign data_arr[r] = bus.data_i[r*DWIDTH +: DWIDTH];
  end

  // First set request at or after ptr, wrapping at NREQ.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned j;
      j = 32'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found_c && bus.req_i[PTR_W'(j)]) begin
        found_c = 1'b1;
        win_c   = PTR_W'(j);
      end
    end
  end

  // Write path; reset gates the write so an in-flight byte is never committed.
  always_comb begin
    accept_c = hresetn && (state_q == XFER) && bus.req_i[gidx_q] && !bus.wf_full_i;
    ack_c    = '0;
    if (accept_c) ack_c[gidx_q] = 1'b1;
  end

  assign bus.ack_o      = ack_c;
  assign bus.wf_we_o    = accept_c;
  assign bus.wf_wdata_o = accept_c ? data_arr[gidx_q] : '0;
  assign bus.grant_o    = grant_q;
  assign bus.busy_o     = (state_q == XFER);

  // Packet end, burst limit, or abandon all end the grant.
  assign release_c = (accept_c && (bus.last_i[gidx_q] || (cnt_q == CNT_W'(MAX_BURST - 1))))
                   || !bus.req_i[gidx_q];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d        = XFER;
          grant_d        = '0;
          grant_d[win_c] = 1'b1;
          gidx_d         = win_c;
          cnt_d          = '0;
        end
      end
      XFER: begin
        if (accept_c) cnt_d = cnt_q + CNT_W'(1);
        if (release_c) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = ((32'(gidx_q) + 32'd1) >= NREQ) ? '0 : gidx_q + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
